// File: rtl/texture_mapper_mult_pkg.sv
// rtl/texture_mapper_mult_pkg.sv - shared constants and sizing helper for the multiplier stream
package texture_mapper_mult_pkg;

    localparam string REPR_UNSIGNED = "UNSIGNED";
    localparam string REPR_SIGNED   = "SIGNED";

    // Width needed to hold values 0..n-1, never less than one bit
    function automatic int tm_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/texture_mapper_legup_mult_pipelined.sv
// rtl/texture_mapper_legup_mult_pipelined.sv - free-running multiplier with PIPELINE output register stages
module texture_mapper_legup_mult_pipelined
    import texture_mapper_mult_pkg::*;
#(
    parameter int    WIDTHA         = 32,
    parameter int    WIDTHB         = 32,
    parameter int    WIDTHP         = 64,
    parameter int    PIPELINE       = 3,
    parameter string REPRESENTATION = REPR_UNSIGNED
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              clken,
    input  logic [WIDTHA-1:0] dataa,
    input  logic [WIDTHB-1:0] datab,
    output logic [WIDTHP-1:0] result
);

    localparam int FW = WIDTHA + WIDTHB;
    localparam int EW = (WIDTHP > FW) ? WIDTHP : FW;

    logic [EW-1:0] a_ext;
    logic [EW-1:0] b_ext;
    logic [EW-1:0] prod_ext;

    // Operands are extended to the full width first so the low bits of the product are exact
    generate
        if (REPRESENTATION == REPR_SIGNED) begin : g_signed
            assign a_ext = {{(EW-WIDTHA){dataa[WIDTHA-1]}}, dataa};
            assign b_ext = {{(EW-WIDTHB){datab[WIDTHB-1]}}, datab};
        end else begin : g_unsigned
            assign a_ext = {{(EW-WIDTHA){1'b0}}, dataa};
            assign b_ext = {{(EW-WIDTHB){1'b0}}, datab};
        end
    endgenerate

    assign prod_ext = a_ext * b_ext;

    generate
        if (PIPELINE == 0) begin : g_comb
            assign result = prod_ext[WIDTHP-1:0];
        end else begin : g_pipe
            logic [WIDTHP-1:0] stage_q [PIPELINE];

            always_ff @(posedge clock) begin
                if (aclr) begin
                    for (int i = 0; i < PIPELINE; i++) stage_q[i] <= '0;
                end else if (clken) begin
                    stage_q[0] <= prod_ext[WIDTHP-1:0];
                    for (int i = 1; i < PIPELINE; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign result = stage_q[PIPELINE-1];
        end
    endgenerate

endmodule

// File: rtl/texture_mapper_mult_result_fifo.sv
// rtl/texture_mapper_mult_result_fifo.sv - circular result buffer with pointers and occupancy count
module texture_mapper_mult_result_fifo
    import texture_mapper_mult_pkg::*;
#(
    parameter int WIDTH = 72,
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             valid_o
);

    localparam int PW = tm_clog2(DEPTH);
    localparam int CW = tm_clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             rd;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid_o   = (count_q != '0);
    assign rd        = rd_en_i && valid_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (wr_en_i && !rd)      count_d = count_q + CW'(1);
        else if (rd && !wr_en_i) count_d = count_q - CW'(1);
    end

    // At full occupancy a write lands in the slot being popped in the same edge
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (rd) rd_ptr_q <= ptr_next(rd_ptr_q);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/texture_mapper_mult_stream.sv
// rtl/texture_mapper_mult_stream.sv - credit-controlled valid/ready wrapper around the pipelined multiplier
module texture_mapper_mult_stream
    import texture_mapper_mult_pkg::*;
#(
    parameter int    WIDTHA         = 32,
    parameter int    WIDTHB         = 32,
    parameter int    WIDTHP         = 64,
    parameter int    PIPELINE       = 3,
    parameter string REPRESENTATION = REPR_UNSIGNED,
    parameter int    TAG_WIDTH      = 8,
    parameter int    FIFO_DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTHA-1:0]    in_a,
    input  logic [WIDTHB-1:0]    in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTHP-1:0]    out_data,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int CW = tm_clog2(FIFO_DEPTH + 1);

    logic                        accept;
    logic                        pop;
    logic [CW-1:0]               credits_q;
    logic [CW-1:0]               credits_d;
    logic [WIDTHP-1:0]           mult_result;
    logic                        wr_en;
    logic [TAG_WIDTH-1:0]        wr_tag;
    logic [WIDTHP+TAG_WIDTH-1:0] rd_data;

    // A credit is held from accept until pop, so every in-flight product has a reserved slot
    assign in_ready = (credits_q != '0) && !reset;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_comb begin
        credits_d = credits_q;
        if (accept && !pop)      credits_d = credits_q - CW'(1);
        else if (pop && !accept) credits_d = credits_q + CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) credits_q <= CW'(FIFO_DEPTH);
        else       credits_q <= credits_d;
    end

    texture_mapper_legup_mult_pipelined #(
        .WIDTHA         (WIDTHA),
        .WIDTHB         (WIDTHB),
        .WIDTHP         (WIDTHP),
        .PIPELINE       (PIPELINE),
        .REPRESENTATION (REPRESENTATION)
    ) u_mult (
        .clock  (clock),
        .aclr   (reset),
        .clken  (1'b1),
        .dataa  (in_a),
        .datab  (in_b),
        .result (mult_result)
    );

    generate
        if (PIPELINE == 0) begin : g_no_pipe
            assign wr_en  = accept;
            assign wr_tag = in_tag;
        end else begin : g_vld_pipe
            logic [PIPELINE-1:0]  vld_q;
            logic [TAG_WIDTH-1:0] tag_q [PIPELINE];

            always_ff @(posedge clock) begin
                if (reset) begin
                    vld_q <= '0;
                    for (int i = 0; i < PIPELINE; i++) tag_q[i] <= '0;
                end else begin
                    vld_q[0] <= accept;
                    tag_q[0] <= in_tag;
                    for (int i = 1; i < PIPELINE; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        tag_q[i] <= tag_q[i-1];
                    end
                end
            end

            assign wr_en  = vld_q[PIPELINE-1];
            assign wr_tag = tag_q[PIPELINE-1];
        end
    endgenerate

    texture_mapper_mult_result_fifo #(
        .WIDTH (WIDTHP + TAG_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_i   (clock),
        .reset_i   (reset),
        .wr_en_i   (wr_en),
        .wr_data_i ({wr_tag, mult_result}),
        .rd_en_i   (out_ready),
        .rd_data_o (rd_data),
        .valid_o   (out_valid)
    );

    assign out_data = rd_data[WIDTHP-1:0];
    assign out_tag  = rd_data[WIDTHP +: TAG_WIDTH];

endmodule

// File: tb/tb_texture_mapper_mult_stream.sv
// tb/tb_texture_mapper_mult_stream.sv - directed self-checking bench for texture_mapper_mult_stream
module tb_texture_mapper_mult_stream;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b;
    logic [7:0]  in_tag, out_tag;
    logic [63:0] out_data;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0]  s_in_a, s_in_b, s_in_tag, s_out_tag;
    logic [15:0] s_out_data;

    always #5 clock = ~clock;

    texture_mapper_mult_stream dut (
        .clock (clock), .reset (reset),
        .in_valid (in_valid), .in_ready (in_ready),
        .in_a (in_a), .in_b (in_b), .in_tag (in_tag),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_data (out_data), .out_tag (out_tag)
    );

    texture_mapper_mult_stream #(
        .WIDTHA (8), .WIDTHB (8), .WIDTHP (16), .REPRESENTATION ("SIGNED")
    ) dut_s (
        .clock (clock), .reset (reset),
        .in_valid (s_in_valid), .in_ready (s_in_ready),
        .in_a (s_in_a), .in_b (s_in_b), .in_tag (s_in_tag),
        .out_valid (s_out_valid), .out_ready (s_out_ready),
        .out_data (s_out_data), .out_tag (s_out_tag)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_acc = 0;
    int n_pop = 0;
    int n_stale = 0;
    logic [63:0] exp_data [$];
    logic [7:0]  exp_tag  [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard the main instance for the handshakes about to happen, then advance one clock
    task automatic cycle();
        if (out_valid && out_ready && !reset) begin
            n_pop++;
            if (exp_data.size() == 0) begin
                n_stale++;
            end else begin
                chk("pop_data", out_data, exp_data.pop_front());
                chk("pop_tag", {56'b0, out_tag}, {56'b0, exp_tag.pop_front()});
            end
        end
        if (in_valid && in_ready) begin
            n_acc++;
            exp_data.push_back({32'b0, in_a} * {32'b0, in_b});
            exp_tag.push_back(in_tag);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int lat, base_acc, base_pop, k;
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_tag = '0; s_out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        reset = 1'b0;
        cycle();
        chk("rel_in_ready", in_ready, 1);
        chk("rel_s_in_ready", s_in_ready, 1);

        // single item: 7*6 with tag 0x11
        out_ready = 1'b1; in_a = 7; in_b = 6; in_tag = 8'h11; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin cycle(); lat++; end
        chk("single_latency", lat, 4);
        chk("single_data", out_data, 42);
        chk("single_tag", out_tag, 8'h11);
        cycle();
        chk("single_hold", out_valid, 0);

        // streaming a=i, b=i+1
        base_acc = n_acc; base_pop = n_pop; k = 0;
        while (n_acc - base_acc < 16 && k < 80) begin
            in_a = n_acc - base_acc; in_b = n_acc - base_acc + 1;
            in_tag = 8'h20 + 8'(n_acc - base_acc); in_valid = 1'b1;
            cycle(); k++;
        end
        in_valid = 1'b0; k = 0;
        while (n_pop - base_pop < 16 && k < 40) begin cycle(); k++; end
        chk("stream_accepts", n_acc - base_acc, 16);
        chk("stream_pops", n_pop - base_pop, 16);

        // backpressure
        base_acc = n_acc; out_ready = 1'b0; in_valid = 1'b1;
        in_a = 32'h1234; in_b = 32'h10; in_tag = 8'h40;
        repeat (8) cycle();
        chk("bp_accepts", n_acc - base_acc, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("bp_ready_after_pop", in_ready, 1);
        in_a = 32'h5; in_tag = 8'h41;
        cycle();
        chk("bp_ready_after_one", in_ready, 0);
        repeat (4) cycle();
        chk("bp_accepts_total", n_acc - base_acc, 5);

        // credits=1 then accept and pop in the same cycle
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_tag = 8'h42;
        cycle();
        out_ready = 1'b0; in_a = 32'h3; in_b = 32'h3; in_tag = 8'h43;
        base_acc = n_acc;
        repeat (6) cycle();
        chk("simul_credits", n_acc - base_acc, 1);
        in_valid = 1'b0; out_ready = 1'b1; k = 0;
        while (exp_data.size() != 0 && k < 40) begin cycle(); k++; end
        chk("drain_empty", exp_data.size(), 0);
        cycle();
        chk("drain_out_valid", out_valid, 0);

        // signed 8x8->16
        out_ready = 1'b0; s_out_ready = 1'b1;
        s_in_a = 8'hFD; s_in_b = 8'd5; s_in_tag = 8'h71; s_in_valid = 1'b1;
        cycle();
        s_in_valid = 1'b0; k = 0;
        while (!s_out_valid && k < 10) begin cycle(); k++; end
        chk("signed_m3x5", s_out_data, 16'hFFF1);
        chk("signed_m3x5_tag", s_out_tag, 8'h71);
        cycle();
        s_in_a = 8'h80; s_in_b = 8'h80; s_in_tag = 8'h72; s_in_valid = 1'b1;
        cycle();
        s_in_valid = 1'b0; k = 0;
        while (!s_out_valid && k < 10) begin cycle(); k++; end
        chk("signed_m128sq", s_out_data, 16'h4000);
        chk("signed_m128sq_tag", s_out_tag, 8'h72);
        cycle();

        // reset with 2 in the FIFO and 2 in flight
        out_ready = 1'b0; in_valid = 1'b1; in_b = 3;
        for (int i = 0; i < 4; i++) begin
            in_a = i + 2; in_tag = 8'h60 + 8'(i);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("mid_out_valid", out_valid, 1);
        reset = 1'b1;
        exp_data.delete(); exp_tag.delete();
        chk("mid_rst_in_ready", in_ready, 0);
        cycle();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_tag", out_tag, 0);
        cycle();
        reset = 1'b0; n_stale = 0; out_ready = 1'b1;
        repeat (8) cycle();
        chk("no_stale", n_stale, 0);

        out_ready = 1'b0; in_valid = 1'b1; in_a = 9; in_b = 11; in_tag = 8'h5A;
        base_acc = n_acc;
        repeat (8) cycle();
        chk("post_rst_credits", n_acc - base_acc, 4);
        in_valid = 1'b0;
        chk("post_rst_data", out_data, 99);
        chk("post_rst_tag", out_tag, 8'h5A);
        out_ready = 1'b1; k = 0;
        while (exp_data.size() != 0 && k < 40) begin cycle(); k++; end
        chk("post_rst_drain", exp_data.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
